// File: rtl/btn_debounce3.sv
// Three-channel button conditioner: two-flop sync, per-channel stability counter,
// sticky press flags. Optional press-event logic under `BTN_DEBOUNCE_EVENT_EN.

module btn_debounce3_ch #(
   parameter  int DB_CYCLES = 60000,
   localparam int CW        = $clog2(DB_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic accept,
   output logic rise
);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // accept: the synchronised level has been stable long enough and LEVEL flips this edge
   assign accept = (sync[1] != level) && (cnt == CNT_MAX);
   assign rise   = accept & ~level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module btn_debounce3 #(
   parameter int DB_CYCLES = 60000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN1,
   input  logic       BTN2,
   input  logic       BTN3,
   input  logic       CLR,
   output logic [2:0] LEVEL,
   output logic [2:0] PRESS,
   output logic       CHG,
   output logic [7:0] STATUS
);
   localparam int NUM_CH = 3;

   logic [NUM_CH-1:0] btn_v;
   logic [NUM_CH-1:0] acc;
   logic [NUM_CH-1:0] rise;

   assign btn_v = {BTN3, BTN2, BTN1};

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      btn_debounce3_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
         .clk    (CLK),
         .rst    (RST),
         .btn    (btn_v[gi]),
         .level  (LEVEL[gi]),
         .accept (acc[gi]),
         .rise   (rise[gi])
      );
   end

   // One CHG pulse covers any number of channels flipping on the same edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) CHG <= 1'b0;
      else     CHG <= |acc;
   end

`ifdef BTN_DEBOUNCE_EVENT_EN
   logic [NUM_CH-1:0] press_q;

   // A set on the same edge as CLR wins, so no press is lost
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) press_q <= '0;
      else     press_q <= (CLR ? '0 : press_q) | rise;
   end

   assign PRESS  = press_q;
   assign STATUS = {2'b00, PRESS, LEVEL};
`else
   logic unused_ev;
   assign unused_ev = CLR | (|rise);
   assign PRESS     = '0;
   assign STATUS    = {5'd0, LEVEL};
`endif
endmodule

// File: doc/btn_debounce3.md
# btn_debounce3

Three-channel push-button conditioner for the Pmod 5LED/3-button board. It sits between the raw BTN1..BTN3 pins and the 8-bit host-bound status byte that the com1 serial link transmits. It synchronises each button, debounces it with a per-channel stability counter, and latches sticky press events until the host side acknowledges them. The packed status byte replaces the direct `{5'd0, BTN3, BTN2, BTN1}` assignment in the top level.

## Interface
Parameters:
- DB_CYCLES, 60000 — consecutive stable clocks needed to accept a new level; 5 ms at 12 MHz; legal range 2..2^20.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  asynchronous, active-high reset
- BTN1  input  1  raw button, active-high (1 = pressed)
- BTN2  input  1  raw button, active-high
- BTN3  input  1  raw button, active-high
- CLR  input  1  single-cycle pulse; clears all press-event flags
- LEVEL  output  3  debounced levels {BTN3, BTN2, BTN1}
- PRESS  output  3  sticky press-event flags, bit order as LEVEL
- CHG  output  1  one-cycle pulse when any LEVEL bit changes
- STATUS  output  8  {2'b00, PRESS[2:0], LEVEL[2:0]}; drives com1 DATA_OUT0

## Operation
- Reset: both synchroniser stages, counters, LEVEL, PRESS and CHG all go to 0. STATUS = 8'h00. Reset takes effect immediately and asynchronously, including mid-count.
- Per channel i:
  - Two-flop synchroniser produces s[i].
  - Counter cnt[i] has width $clog2(DB_CYCLES).
- Per-channel update, each clock:
  - s[i] == LEVEL[i]: cnt[i] <= 0.
  - else, cnt[i] == DB_CYCLES-1: LEVEL[i] <= s[i], cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- A glitch shorter than DB_CYCLES clocks (after sync) restarts the count and never changes LEVEL. The counter never wraps.
- Press event: PRESS[i] is set on the same edge that LEVEL[i] goes 0->1. A 1->0 transition sets no flag.
- Flag behaviour:
  - PRESS flags are independent per channel.
  - A set on an already-set flag has no effect. There is no count and no overflow indication.
  - CLR=1 clears all three flags on the next edge.
  - If CLR and a set of the same bit occur on the same edge, the set wins (the event is not lost). Other bits still clear.
- CHG is registered. It is 1 for exactly the clock following any edge that changed any LEVEL bit, and 0 otherwise.
- STATUS is pure combinational packing of the registered outputs. It adds no latency.

## Timing
- Raw BTN change to s[i]: 2 clocks.
- Raw BTN change stable to LEVEL update: 2 + DB_CYCLES clocks.
- PRESS updates on the same edge as LEVEL. CHG is high for the cycle starting at that edge.
- CLR to PRESS cleared: 1 clock.
- Simultaneous changes on several channels: each channel is evaluated independently. A single CHG pulse is produced if they update on the same edge.
- RST deassertion: the first counting edge is the first rising CLK after release. Buttons held during reset are accepted 2 + DB_CYCLES clocks after release and set PRESS.

## Configuration
- BTN_DEBOUNCE_EVENT_EN defined: PRESS flags and CLR behave as above.
- Not defined:
  - PRESS is tied to 3'b000 and CLR is ignored. CHG, LEVEL and STATUS[2:0] are unchanged.
  - STATUS = {5'd0, LEVEL}, which is bit-compatible with the undebounced top level.

## Test plan
All scenarios run with DB_CYCLES=4.
- Reset mid-count: hold BTN1=1 for 3 clocks, assert RST for 1 clock, release. Required: all outputs 0 during reset; LEVEL[0] rises exactly 6 clocks after RST release.
- Clean press: BTN2 0->1 held. Required: LEVEL=3'b010, PRESS=3'b010, STATUS=8'h12 at clock 6; CHG high for that one cycle only.
- Bounce: BTN1 toggles 1,0,1,0 every 2 clocks, then 1 steady. Required: LEVEL[0] stays 0 through the bounce and rises 6 clocks after the final 0->1; exactly one CHG pulse.
- Release plus clear: after the clean-press scenario, BTN2 -> 0, then pulse CLR. Required: LEVEL=0 after 6 clocks with PRESS still 3'b010; PRESS=0 one clock after CLR; STATUS=8'h00.
- CLR/set collision: pulse CLR on the exact edge LEVEL[2] rises, with PRESS[0] already set. Required: PRESS=3'b100 afterwards.
- Macro undefined: repeat the clean press. Required: STATUS=8'h02 and PRESS=0 throughout.
